hazard_scoreboard: RTL and testbench

Parametrised successor to the single-cycle hazard unit. Besides load-use, branch-flush, bus-wait and invalid-instruction handling, it tracks long-latency register writebacks (loads over AXI4-Lite, multi-cycle MUL/DIV) in an in-order scoreboard of configurable depth. It stalls decode on any RAW hit against pending destinations and counts stall cycles for performance monitoring. It sits beside the ID/EX/MEM/WB pipeline registers and drives all of their enables and flushes.

---
 rtl/hazard_scoreboard.sv | 163 ++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard control with an in-order scoreboard of pending long-latency writebacks.
// Optional macro HAZARD_WB_BYPASS_EN: the head entry retiring this cycle no longer blocks decode.
module hazard_scoreboard #(
    parameter int PEND_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [4:0]                    id_rs1,
    input  logic [4:0]                    id_rs2,
    input  logic                          id_rs1_used,
    input  logic                          id_rs2_used,
    input  logic [4:0]                    ex_rd,
    input  logic                          ex_load_inst,
    input  logic                          ex_long_inst,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_rd,
    input  logic                          jump_branch_taken,
    input  logic                          mem_read_write,
    input  logic                          stall,
    input  logic                          invalid_inst,
    output logic                          if_id_pipeline_flush,
    output logic                          if_id_pipeline_en,
    output logic                          id_ex_pipeline_flush,
    output logic                          id_ex_pipeline_en,
    output logic                          ex_mem_pipeline_stall,
    output logic                          ex_mem_pipeline_flush,
    output logic                          mem_wb_pipeline_en,
    output logic                          pc_en,
    output logic                          load_stall,
    output logic                          sb_full,
    output logic [$clog2(PEND_DEPTH):0]   sb_count,
    output logic                          wb_err,
    output logic [CNT_W-1:0]              stall_cycles
);

    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [4:0]       rd_q [PEND_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count;
    logic [PEND_DEPTH-1:0] entry_live;
    logic             push;
    logic             pop;
    logic             hit_rs1;
    logic             hit_rs2;
    logic             ex_hit;
    logic             src_hit;
    logic             head_retiring;

    assign sb_full  = (count == CW'(PEND_DEPTH));
    assign sb_count = count;

    assign push = ex_long_inst && (ex_rd != 5'd0) && !sb_full && !mem_read_write && !jump_branch_taken;
    assign pop  = wb_valid && (count != '0);

    assign head_retiring = pop && (wb_rd == rd_q[head]);

    // An entry is live if it lies within count slots of head (circular distance).
    always_comb begin
        entry_live = '0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            entry_live[i] = ({1'b0, PTR_W'(i) - head} < count);
`ifdef HAZARD_WB_BYPASS_EN
            if (head_retiring && (PTR_W'(i) == head))
                entry_live[i] = 1'b0;
`endif
        end
    end

    always_comb begin
        hit_rs1 = 1'b0;
        hit_rs2 = 1'b0;
        for (int i = 0; i < PEND_DEPTH; i++) begin
            if (entry_live[i] && (rd_q[i] == id_rs1) && (id_rs1 != 5'd0))
                hit_rs1 = 1'b1;
            if (entry_live[i] && (rd_q[i] == id_rs2) && (id_rs2 != 5'd0))
                hit_rs2 = 1'b1;
        end
    end

    assign src_hit = (id_rs1_used && hit_rs1) || (id_rs2_used && hit_rs2);

    assign ex_hit = (ex_load_inst || ex_long_inst) && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        if_id_pipeline_flush  = 1'b0;
        if_id_pipeline_en     = 1'b1;
        id_ex_pipeline_flush  = 1'b0;
        id_ex_pipeline_en     = 1'b1;
        ex_mem_pipeline_stall = 1'b0;
        ex_mem_pipeline_flush = 1'b0;
        mem_wb_pipeline_en    = 1'b1;
        pc_en                 = 1'b1;
        load_stall            = 1'b0;
        if (jump_branch_taken) begin
            if_id_pipeline_flush  = 1'b1;
            if_id_pipeline_en     = 1'b0;
            id_ex_pipeline_flush  = 1'b1;
            ex_mem_pipeline_flush = 1'b1;
        end else if (mem_read_write) begin
            if_id_pipeline_en     = 1'b0;
            id_ex_pipeline_en     = 1'b0;
            pc_en                 = 1'b0;
            mem_wb_pipeline_en    = 1'b0;
            ex_mem_pipeline_stall = 1'b1;
        end else if (sb_full && ex_long_inst) begin
            // Hold the long op in EX and send a bubble downstream until a slot frees.
            if_id_pipeline_en     = 1'b0;
            id_ex_pipeline_en     = 1'b0;
            pc_en                 = 1'b0;
            ex_mem_pipeline_flush = 1'b1;
        end else if (ex_hit) begin
            if_id_pipeline_en     = 1'b0;
            pc_en                 = 1'b0;
            id_ex_pipeline_flush  = 1'b1;
            load_stall            = 1'b1;
        end else if (src_hit) begin
            if_id_pipeline_en     = 1'b0;
            pc_en                 = 1'b0;
            id_ex_pipeline_flush  = 1'b1;
        end else if (stall) begin
            if_id_pipeline_en     = 1'b0;
            id_ex_pipeline_en     = 1'b0;
            pc_en                 = 1'b0;
        end else if (invalid_inst) begin
            id_ex_pipeline_flush  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            rd_q[tail] <= ex_rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            wb_err       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if ((wb_valid && (count == '0)) || (pop && (wb_rd != rd_q[head])))
                wb_err <= 1'b1;
            if (!pc_en && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: pipeline control priority, scoreboard occupancy and errors.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd, wb_rd;
    logic        id_rs1_used, id_rs2_used, ex_load_inst, ex_long_inst, wb_valid;
    logic        jump_branch_taken, mem_read_write, stall, invalid_inst;
    logic        if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush, id_ex_pipeline_en;
    logic        ex_mem_pipeline_stall, ex_mem_pipeline_flush, mem_wb_pipeline_en, pc_en, load_stall;
    logic        sb_full, wb_err;
    logic [2:0]  sb_count;
    logic [15:0] stall_cycles;
    logic [8:0]  ctrl;

    int checks = 0;
    int passes = 0;

    // {if_id_flush, if_id_en, id_ex_flush, id_ex_en, ex_mem_stall, ex_mem_flush, mem_wb_en, pc_en, load_stall}
    localparam logic [8:0] CTRL_DEF  = 9'b010100110;
    localparam logic [8:0] CTRL_BR   = 9'b101101110;
    localparam logic [8:0] CTRL_MEM  = 9'b000010000;
    localparam logic [8:0] CTRL_FULL = 9'b000001100;
    localparam logic [8:0] CTRL_EXH  = 9'b001100101;
    localparam logic [8:0] CTRL_SBH  = 9'b001100100;
    localparam logic [8:0] CTRL_STL  = 9'b000000100;
    localparam logic [8:0] CTRL_INV  = 9'b011100110;

    hazard_scoreboard #(.PEND_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_load_inst(ex_load_inst), .ex_long_inst(ex_long_inst),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .jump_branch_taken(jump_branch_taken), .mem_read_write(mem_read_write),
        .stall(stall), .invalid_inst(invalid_inst),
        .if_id_pipeline_flush(if_id_pipeline_flush), .if_id_pipeline_en(if_id_pipeline_en),
        .id_ex_pipeline_flush(id_ex_pipeline_flush), .id_ex_pipeline_en(id_ex_pipeline_en),
        .ex_mem_pipeline_stall(ex_mem_pipeline_stall), .ex_mem_pipeline_flush(ex_mem_pipeline_flush),
        .mem_wb_pipeline_en(mem_wb_pipeline_en), .pc_en(pc_en), .load_stall(load_stall),
        .sb_full(sb_full), .sb_count(sb_count), .wb_err(wb_err), .stall_cycles(stall_cycles)
    );

    assign ctrl = {if_id_pipeline_flush, if_id_pipeline_en, id_ex_pipeline_flush, id_ex_pipeline_en,
                   ex_mem_pipeline_stall, ex_mem_pipeline_flush, mem_wb_pipeline_en, pc_en, load_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle;
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_rd = 0; ex_load_inst = 0; ex_long_inst = 0; wb_valid = 0; wb_rd = 0;
        jump_branch_taken = 0; mem_read_write = 0; stall = 0; invalid_inst = 0;
    endtask

    // Inputs change on the falling edge; the rising edge sits 5 time units later.
    task automatic do_reset;
        @(negedge clk); idle; rst_n = 0;
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_reset;
        @(negedge clk); idle; rst_n = 0;
        @(negedge clk); @(negedge clk); rst_n = 1; #1;
        checks++; if (sb_count !== 3'd0) $display("FAIL reset_count got %0d exp 0", sb_count); else passes++;
        checks++; if (sb_full !== 1'b0) $display("FAIL reset_full got %b exp 0", sb_full); else passes++;
        checks++; if (wb_err !== 1'b0) $display("FAIL reset_wb_err got %b exp 0", wb_err); else passes++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall_cycles got %0d exp 0", stall_cycles); else passes++;
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL reset_ctrl got %b exp %b", ctrl, CTRL_DEF); else passes++;
    endtask

    task automatic test_priority;
        do_reset;
        mem_read_write = 1; stall = 1; invalid_inst = 1; ex_long_inst = 1; ex_rd = 12; #1;
        checks++; if (ctrl !== CTRL_MEM) $display("FAIL prio_mem got %b exp %b", ctrl, CTRL_MEM); else passes++;
        @(negedge clk); jump_branch_taken = 1; #1;
        checks++; if (ctrl !== CTRL_BR) $display("FAIL prio_branch got %b exp %b", ctrl, CTRL_BR); else passes++;
        checks++; if (sb_count !== 3'd0) $display("FAIL prio_no_push got %0d exp 0", sb_count); else passes++;
        @(negedge clk); idle; stall = 1; invalid_inst = 1; #1;
        checks++; if (ctrl !== CTRL_STL) $display("FAIL prio_stall got %b exp %b", ctrl, CTRL_STL); else passes++;
        @(negedge clk); idle; invalid_inst = 1; #1;
        checks++; if (ctrl !== CTRL_INV) $display("FAIL prio_invalid got %b exp %b", ctrl, CTRL_INV); else passes++;
        @(negedge clk); idle; ex_load_inst = 1; ex_long_inst = 1; ex_rd = 0; id_rs1_used = 1; #1;
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL x0_no_hazard got %b exp %b", ctrl, CTRL_DEF); else passes++;
        @(negedge clk); idle; #1;
        checks++; if (sb_count !== 3'd0) $display("FAIL x0_no_push got %0d exp 0", sb_count); else passes++;
    endtask

    task automatic test_load_use;
        do_reset;
        ex_rd = 5; ex_load_inst = 1; ex_long_inst = 1; id_rs1 = 5; id_rs1_used = 1; #1;
        checks++; if (ctrl !== CTRL_EXH) $display("FAIL load_use_ctrl got %b exp %b", ctrl, CTRL_EXH); else passes++;
        @(negedge clk); ex_rd = 0; ex_load_inst = 0; ex_long_inst = 0; #1;
        checks++; if (sb_count !== 3'd1) $display("FAIL load_use_count got %0d exp 1", sb_count); else passes++;
        checks++; if (stall_cycles !== 16'd1) $display("FAIL load_use_stall_cycles got %0d exp 1", stall_cycles); else passes++;
        checks++; if (ctrl !== CTRL_SBH) $display("FAIL load_use_pending got %b exp %b", ctrl, CTRL_SBH); else passes++;
        @(negedge clk); idle; wb_valid = 1; wb_rd = 5;
        @(negedge clk); idle; #1;
        checks++; if (sb_count !== 3'd0) $display("FAIL load_use_drain got %0d exp 0", sb_count); else passes++;
        checks++; if (stall_cycles !== 16'd2) $display("FAIL load_use_stall_total got %0d exp 2", stall_cycles); else passes++;
    endtask

    task automatic test_div_latency;
        int exp_st;
        do_reset;
        id_rs1 = 7; id_rs2 = 1; id_rs1_used = 1; id_rs2_used = 1; ex_long_inst = 1; ex_rd = 7; #1;
        checks++; if (ctrl !== CTRL_EXH) $display("FAIL div_issue got %b exp %b", ctrl, CTRL_EXH); else passes++;
        exp_st = 1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk); ex_long_inst = 0; ex_rd = 0; #1;
            checks++; if (ctrl !== CTRL_SBH) $display("FAIL div_wait cycle %0d got %b exp %b", c, ctrl, CTRL_SBH); else passes++;
            exp_st++;
        end
        @(negedge clk); wb_valid = 1; wb_rd = 7; #1;
`ifdef HAZARD_WB_BYPASS_EN
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL div_wb_cycle got %b exp %b", ctrl, CTRL_DEF); else passes++;
`else
        checks++; if (ctrl !== CTRL_SBH) $display("FAIL div_wb_cycle got %b exp %b", ctrl, CTRL_SBH); else passes++;
        exp_st++;
`endif
        @(negedge clk); wb_valid = 0; wb_rd = 0; #1;
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL div_release got %b exp %b", ctrl, CTRL_DEF); else passes++;
        checks++; if (stall_cycles !== 16'(exp_st)) $display("FAIL div_stall_cycles got %0d exp %0d", stall_cycles, exp_st); else passes++;
        checks++; if (sb_count !== 3'd0) $display("FAIL div_count got %0d exp 0", sb_count); else passes++;
        checks++; if (wb_err !== 1'b0) $display("FAIL div_wb_err got %b exp 0", wb_err); else passes++;
    endtask

    task automatic test_full;
        logic [4:0] drain [4];
        drain = '{5'd2, 5'd3, 5'd4, 5'd10};
        do_reset;
        for (int r = 1; r <= 4; r++) begin
            idle; ex_long_inst = 1; ex_rd = 5'(r); #1;
            checks++; if (ctrl !== CTRL_DEF) $display("FAIL full_fill %0d got %b exp %b", r, ctrl, CTRL_DEF); else passes++;
            @(negedge clk);
        end
        ex_rd = 10; ex_long_inst = 1; #1;
        checks++; if (sb_full !== 1'b1) $display("FAIL full_flag got %b exp 1", sb_full); else passes++;
        checks++; if (sb_count !== 3'd4) $display("FAIL full_count got %0d exp 4", sb_count); else passes++;
        checks++; if (ctrl !== CTRL_FULL) $display("FAIL full_ctrl got %b exp %b", ctrl, CTRL_FULL); else passes++;
        @(negedge clk); #1;
        checks++; if (ctrl !== CTRL_FULL) $display("FAIL full_hold got %b exp %b", ctrl, CTRL_FULL); else passes++;
        @(negedge clk); wb_valid = 1; wb_rd = 1; #1;
        checks++; if (ctrl !== CTRL_FULL) $display("FAIL full_wb_cycle got %b exp %b", ctrl, CTRL_FULL); else passes++;
        @(negedge clk); wb_valid = 0; wb_rd = 0; #1;
        checks++; if (sb_count !== 3'd3) $display("FAIL full_after_pop got %0d exp 3", sb_count); else passes++;
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL full_release got %b exp %b", ctrl, CTRL_DEF); else passes++;
        @(negedge clk); idle; #1;
        checks++; if (sb_count !== 3'd4) $display("FAIL full_retry_push got %0d exp 4", sb_count); else passes++;
        for (int k = 0; k < 4; k++) begin
            wb_valid = 1; wb_rd = drain[k];
            @(negedge clk);
        end
        idle; #1;
        checks++; if (sb_count !== 3'd0) $display("FAIL full_drain got %0d exp 0", sb_count); else passes++;
        checks++; if (wb_err !== 1'b0) $display("FAIL full_wrap_order got %b exp 0", wb_err); else passes++;
    endtask

    task automatic test_branch;
        do_reset;
        ex_long_inst = 1; ex_rd = 9;
        @(negedge clk); jump_branch_taken = 1; ex_rd = 11; #1;
        checks++; if (ctrl !== CTRL_BR) $display("FAIL branch_ctrl got %b exp %b", ctrl, CTRL_BR); else passes++;
        @(negedge clk); idle; #1;
        checks++; if (sb_count !== 3'd1) $display("FAIL branch_count got %0d exp 1", sb_count); else passes++;
        wb_valid = 1; wb_rd = 9;
        @(negedge clk); idle; #1;
        checks++; if (sb_count !== 3'd0) $display("FAIL branch_pop got %0d exp 0", sb_count); else passes++;
        checks++; if (wb_err !== 1'b0) $display("FAIL branch_wb_err got %b exp 0", wb_err); else passes++;
    endtask

    task automatic test_wb_err;
        do_reset;
        ex_long_inst = 1; ex_rd = 2;
        @(negedge clk); ex_rd = 3;
        @(negedge clk); idle; wb_valid = 1; wb_rd = 3; #1;
        checks++; if (wb_err !== 1'b0) $display("FAIL wb_err_before got %b exp 0", wb_err); else passes++;
        @(negedge clk); idle; stall = 1; #1;
        checks++; if (wb_err !== 1'b1) $display("FAIL wb_err_set got %b exp 1", wb_err); else passes++;
        checks++; if (sb_count !== 3'd1) $display("FAIL wb_err_retires got %0d exp 1", sb_count); else passes++;
        checks++; if (ctrl !== CTRL_STL) $display("FAIL wb_err_stall got %b exp %b", ctrl, CTRL_STL); else passes++;
        @(negedge clk); idle; #1;
        checks++; if (wb_err !== 1'b1) $display("FAIL wb_err_sticky got %b exp 1", wb_err); else passes++;
        checks++; if (stall_cycles !== 16'd1) $display("FAIL wb_err_stall_cycles got %0d exp 1", stall_cycles); else passes++;
        rst_n = 0;
        @(negedge clk); rst_n = 1; #1;
        checks++; if (wb_err !== 1'b0) $display("FAIL wb_err_reset got %b exp 0", wb_err); else passes++;
        checks++; if (sb_count !== 3'd0) $display("FAIL wb_err_reset_count got %0d exp 0", sb_count); else passes++;
        checks++; if (stall_cycles !== 16'd0) $display("FAIL wb_err_reset_stalls got %0d exp 0", stall_cycles); else passes++;
        wb_valid = 1; wb_rd = 4;
        @(negedge clk); idle; #1;
        checks++; if (wb_err !== 1'b1) $display("FAIL wb_err_empty_pop got %b exp 1", wb_err); else passes++;
        checks++; if (sb_count !== 3'd0) $display("FAIL wb_err_empty_count got %0d exp 0", sb_count); else passes++;
    endtask

    task automatic test_back_to_back;
        do_reset;
        ex_long_inst = 1; ex_rd = 2;
        @(negedge clk); ex_rd = 4;
        @(negedge clk); ex_rd = 6; wb_valid = 1; wb_rd = 2;
        @(negedge clk); idle; id_rs1 = 2; id_rs1_used = 1; id_rs2 = 4; id_rs2_used = 0; #1;
        checks++; if (sb_count !== 3'd2) $display("FAIL b2b_count got %0d exp 2", sb_count); else passes++;
        checks++; if (ctrl !== CTRL_DEF) $display("FAIL b2b_popped_free got %b exp %b", ctrl, CTRL_DEF); else passes++;
        id_rs2_used = 1; #1;
        checks++; if (ctrl !== CTRL_SBH) $display("FAIL b2b_rs2_hit got %b exp %b", ctrl, CTRL_SBH); else passes++;
        id_rs2_used = 0; id_rs1 = 6; #1;
        checks++; if (ctrl !== CTRL_SBH) $display("FAIL b2b_pushed_hit got %b exp %b", ctrl, CTRL_SBH); else passes++;
        checks++; if (wb_err !== 1'b0) $display("FAIL b2b_wb_err got %b exp 0", wb_err); else passes++;
    endtask

    initial begin
        idle;
        rst_n = 0;
        test_reset;
        test_priority;
        test_load_use;
        test_div_latency;
        test_full;
        test_branch;
        test_wb_err;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
